// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer: MAC register opcodes and sequencer states.
package mac_sequencer_pkg;

    localparam logic [1:0] MAC_HOLD = 2'd0;
    localparam logic [1:0] MAC_LOAD = 2'd1;
    localparam logic [1:0] MAC_ACC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/MACRegister.sv
// 32-bit multiply-accumulate register driven by the sequencer's mac_* ports.
// Load takes {a, b}; MAC adds the unsigned 16x16 product, wrapping modulo 2**32.
module MACRegister
    import mac_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  opcode,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] q
);

    logic [31:0] q_q;

    // Contents after reset are arbitrary; a recognisable pattern exposes a missed clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 32'hDEAD_BEEF;
        end else begin
            case (opcode)
                MAC_LOAD: q_q <= {a, b};
                MAC_ACC:  q_q <= q_q + ({16'd0, a} * {16'd0, b});
                default:  q_q <= q_q;
            endcase
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mac_sequencer.sv
// Sequences an external MAC register to compute an unsigned dot product of two 16-bit vectors.
// Flow per job: clear MAC, stream operand pairs over valid/ready, present the sum on a result handshake.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    input  logic             in_valid,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic             in_ready,
    output logic [1:0]       mac_opcode,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    input  logic [31:0]      mac_data,
    output logic [31:0]      result,
    output logic             result_valid,
    input  logic             result_ready
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [31:0]      result_q, result_d;
    logic             result_valid_q, result_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            remaining_q    <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        mac_opcode     = MAC_HOLD;
        mac_a          = '0;
        mac_b          = '0;
        in_ready       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = length;
                    state_d     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                mac_opcode = MAC_LOAD;
                state_d    = (remaining_q == '0) ? ST_DONE : ST_ACCUM;
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mac_opcode  = MAC_ACC;
                    mac_a       = in_a;
                    mac_b       = in_b;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // First DONE cycle captures the sum (MAC settled on the previous edge);
                // afterwards hold until the consumer takes it.
                if (!result_valid_q) begin
                    result_d       = mac_data;
                    result_valid_d = 1'b1;
                end else if (result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy         = (state_q != ST_IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer driving a MACRegister; expected sums come from a
// plain arithmetic dot-product model and handshake timing from cycle counts.
module tb_mac_sequencer;

    localparam int unsigned LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] length = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic [15:0]      in_a = '0;
    logic [15:0]      in_b = '0;
    logic             in_ready;
    logic [1:0]       mac_opcode;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic [31:0]      mac_data;
    logic [31:0]      result;
    logic             result_valid;
    logic             result_ready = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [15:0] opa [256];
    logic [15:0] opb [256];

    mac_sequencer #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .length       (length),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_ready     (in_ready),
        .mac_opcode   (mac_opcode),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_data     (mac_data),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    MACRegister u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (mac_opcode),
        .a      (mac_a),
        .b      (mac_b),
        .q      (mac_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_dot(input int len);
        longint unsigned acc = 0;
        for (int i = 0; i < len; i++) begin
            acc = acc + longint'(opa[i]) * longint'(opb[i]);
        end
        return acc[31:0];
    endfunction

    // mode: 0 = in_valid always high, 1 = toggling 1,0,1,0..., 2 = random
    task automatic run_job(input string tag, input int len, input int mode,
                           input int hold, input bit pulse_start);
        logic [31:0] exp;
        int          beats;
        int          t0;
        int          guard;
        bit          v;
        exp = model_dot(len);
        start  = 1'b1;
        length = LEN_W'(len);
        t0     = cyc;
        tick();
        start = 1'b0;
        chk({tag, ".clear_op"}, 32'(mac_opcode), 32'd1);
        chk({tag, ".clear_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, ".clear_busy"}, 32'(busy), 32'd1);
        tick();
        beats = 0;
        guard = 0;
        while (beats < len && guard < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 0;
                default: v = $urandom_range(1, 0) == 1;
            endcase
            in_valid = v;
            in_a     = opa[beats];
            in_b     = opb[beats];
            #1;
            chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
            chk({tag, ".opcode"}, 32'(mac_opcode), v ? 32'd2 : 32'd0);
            if (v) begin
                chk({tag, ".mac_ab"}, {mac_a, mac_b}, {opa[beats], opb[beats]});
                beats++;
            end else begin
                chk({tag, ".mac_ab_idle"}, {mac_a, mac_b}, 32'd0);
            end
            tick();
            guard++;
        end
        if (guard >= 2000) chk({tag, ".beat_timeout"}, 32'(beats), 32'(len));
        in_valid = 1'b1;
        in_a     = 16'h5A5A;
        #1;
        chk({tag, ".done_entry_rv"}, 32'(result_valid), 32'd0);
        chk({tag, ".done_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, ".done_op"}, 32'(mac_opcode), 32'd0);
        in_valid = 1'b0;
        tick();
        chk({tag, ".rv"}, 32'(result_valid), 32'd1);
        chk({tag, ".result"}, result, exp);
        if (mode == 0) chk({tag, ".latency"}, 32'(cyc - t0), 32'(len + 3));
        for (int i = 0; i < hold; i++) begin
            start = pulse_start && (i % 2 == 0);
            tick();
            chk({tag, ".hold_rv"}, 32'(result_valid), 32'd1);
            chk({tag, ".hold_res"}, result, exp);
            chk({tag, ".hold_busy"}, 32'(busy), 32'd1);
        end
        start        = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({tag, ".rv_clr"}, 32'(result_valid), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.rdy", 32'(in_ready), 32'd0);
        chk("rst.rv", 32'(result_valid), 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.op", 32'(mac_opcode), 32'd0);
        tick();
        rst_n = 1'b1;
        result_ready = 1'b1;
        tick();
        chk("idle.ready_early", 32'(busy), 32'd0);
        result_ready = 1'b0;

        opa[0] = 16'd1; opb[0] = 16'd2;
        opa[1] = 16'd3; opb[1] = 16'd4;
        opa[2] = 16'd5; opb[2] = 16'd6;
        run_job("t1", 3, 0, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin opa[i] = 16'd10; opb[i] = 16'd10; end
        run_job("t2", 4, 1, 0, 1'b0);

        run_job("t3", 0, 0, 0, 1'b0);

        for (int i = 0; i < 2; i++) begin opa[i] = 16'hFFFF; opb[i] = 16'hFFFF; end
        run_job("t4a", 2, 0, 0, 1'b0);
        opa[0] = 16'd1; opb[0] = 16'd1;
        run_job("t4b", 1, 0, 0, 1'b0);

        opa[0] = 16'd9; opb[0] = 16'd9;
        opa[1] = 16'd2; opb[1] = 16'd7;
        run_job("t5", 2, 0, 5, 1'b1);

        // Reset in the middle of ACCUM after two of five beats
        for (int i = 0; i < 5; i++) begin opa[i] = 16'(i + 1); opb[i] = 16'd100; end
        start = 1'b1; length = LEN_W'(5);
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = opa[i]; in_b = opb[i];
            tick();
        end
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321;
        rst_n = 1'b0;
        #1;
        chk("t6.busy", 32'(busy), 32'd0);
        chk("t6.rdy", 32'(in_ready), 32'd0);
        chk("t6.rv", 32'(result_valid), 32'd0);
        chk("t6.result", result, 32'd0);
        chk("t6.op", 32'(mac_opcode), 32'd0);
        chk("t6.mac_ab", {mac_a, mac_b}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        tick();
        opa[0] = 16'd7; opb[0] = 16'd3;
        run_job("t6b", 1, 0, 0, 1'b0);

        for (int j = 0; j < 6; j++) begin
            int len;
            len = $urandom_range(20, 1);
            for (int i = 0; i < len; i++) begin
                opa[i] = 16'($urandom);
                opb[i] = 16'($urandom);
            end
            run_job($sformatf("rnd%0d", j), len, 2, $urandom_range(3, 0), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
